// File: rtl/mem_seq_pkg.sv
// ---------------------------------------------------------------------------
// mem_seq_pkg
// Shared definitions for the unified-memory access sequencer:
//   - FSM state encoding (IDLE, FETCH, DATA, DONE)
//   - memory access size codes (byte / word)
//   - the NOP instruction word returned on an aborted fetch
// ---------------------------------------------------------------------------
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/mem_seq_legal_chk.sv
// ---------------------------------------------------------------------------
// mem_seq_legal_chk
// Combinational legality check for a data-side access. Only byte accesses
// (any alignment) and naturally aligned word accesses are legal.
//
// Ports:
//   size     in  2  requested access size (00 byte, 10 word)
//   addr_lo  in  2  low two bits of the data address
//   legal    out 1  1 = access may be issued to memory
// ---------------------------------------------------------------------------
module mem_seq_legal_chk
    import mem_seq_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic       legal
);

    always_comb begin
        legal = 1'b0;
        if (size == SZ_BYTE) begin
            legal = 1'b1;
        end else if (size == SZ_WORD) begin
            legal = (addr_lo == 2'b00);
        end
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// ---------------------------------------------------------------------------
// mem_access_sequencer
// Serialises instruction fetch and data load/store onto one unified,
// variable-latency memory port. Data requests win arbitration unless
// MAX_DATA_BURST data grants have already been taken while a fetch was
// waiting, in which case the fetch goes first. pc_write pulses together with
// if_done so the program counter only advances on a completed fetch.
//
// Optional feature (compile-time macro MEM_TIMEOUT_EN): when defined, an
// access that sees no mem_ready within TIMEOUT mem_en cycles is abandoned;
// a data access then completes with dm_err = 1, a fetch returns NOP_WORD.
// Without the macro the sequencer waits for mem_ready indefinitely.
//
// Ports:
//   Clk        in   1       clock, rising edge
//   Reset      in   1       asynchronous reset, active low
//   if_req     in   1       fetch request, held until if_done
//   if_addr    in   ADDR_W  fetch address
//   if_done    out  1       one-cycle fetch-complete pulse
//   if_rdata   out  DATA_W  fetched instruction, held until next if_done
//   pc_write   out  1       copy of if_done for the program counter
//   dm_req     in   1       data request, held until dm_done
//   dm_we      in   1       1 = store, 0 = load
//   dm_size    in   2       00 byte, 10 word
//   dm_addr    in   ADDR_W  data address
//   dm_wdata   in   DATA_W  store data (byte in [7:0])
//   dm_done    out  1       one-cycle data-complete pulse
//   dm_rdata   out  DATA_W  load data (bytes zero-extended)
//   dm_err     out  1       with dm_done: illegal or aborted access
//   mem_en     out  1       memory access strobe
//   mem_we     out  1       memory write enable
//   mem_size   out  2       access size (10 for fetch)
//   mem_addr   out  ADDR_W  memory address
//   mem_wdata  out  DATA_W  memory write data
//   mem_rdata  in   DATA_W  memory read data, valid with mem_ready
//   mem_ready  in   1       memory access completes this cycle
// ---------------------------------------------------------------------------
module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT        = 16
) (
    input  logic              Clk,
    input  logic              Reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              pc_write,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [1:0]        dm_size,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_err,

    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    // Byte-lane handling assumes a 32-bit data path.
    if (DATA_W != 32 || MAX_DATA_BURST < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("mem_access_sequencer: unsupported parameter set");
    end

    localparam int              BURST_W   = $clog2(MAX_DATA_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DATA_BURST);

    state_t              state;
    state_t              next_state;
    logic [BURST_W-1:0]  burst_cnt;

    // Which requester owns the access in flight, and whether it failed.
    logic                acc_data;
    logic                acc_err;

    // Request latches; the mem_* outputs are driven straight from these so
    // they cannot move while mem_en is high.
    logic [ADDR_W-1:0]   lat_addr;
    logic                lat_we;
    logic [1:0]          lat_size;
    logic [DATA_W-1:0]   lat_wdata;

    logic                dm_legal;
    logic                grant_data;
    logic                grant_fetch;
    logic                complete;

`ifdef MEM_TIMEOUT_EN
    localparam int              TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0]    tmo_cnt;
    logic                abort;
`endif

    mem_seq_legal_chk u_legal_chk (
        .size    (dm_size),
        .addr_lo (dm_addr[1:0]),
        .legal   (dm_legal)
    );

    // -----------------------------------------------------------------------
    // Next-state and grant decode
    // -----------------------------------------------------------------------
    always_comb begin
        next_state  = state;
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        complete    = 1'b0;
`ifdef MEM_TIMEOUT_EN
        abort       = 1'b0;
`endif
        case (state)
            IDLE: begin
                // Data has priority until it has starved a waiting fetch for
                // MAX_DATA_BURST grants in a row.
                if (dm_req && ((burst_cnt < BURST_MAX) || !if_req)) begin
                    grant_data = 1'b1;
                    // An illegal access never reaches memory.
                    next_state = dm_legal ? DATA : DONE;
                end else if (if_req) begin
                    grant_fetch = 1'b1;
                    next_state  = FETCH;
                end
            end
            FETCH, DATA: begin
                if (mem_ready) begin
                    complete   = 1'b1;
                    next_state = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    abort      = 1'b1;
                    next_state = DONE;
                end
`endif
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control state: FSM, burst counter, access ownership
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            burst_cnt <= '0;
            acc_data  <= 1'b0;
            acc_err   <= 1'b0;
        end else begin
            state <= next_state;

            if (grant_data) begin
                acc_data <= 1'b1;
                acc_err  <= !dm_legal;
                if (if_req && (burst_cnt != BURST_MAX)) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end

            if (grant_fetch) begin
                acc_data  <= 1'b0;
                acc_err   <= 1'b0;
                burst_cnt <= '0;
            end

`ifdef MEM_TIMEOUT_EN
            if (abort) begin
                acc_err <= 1'b1;
            end
`endif
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Counts mem_en cycles of the access in flight; cleared between accesses.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            tmo_cnt <= '0;
        end else if (mem_en) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Request latches and read-data capture
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_size  <= 2'b00;
            lat_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if (grant_data) begin
                lat_addr  <= dm_addr;
                lat_we    <= dm_we;
                lat_size  <= dm_size;
                lat_wdata <= dm_wdata;
                if (!dm_legal) begin
                    dm_rdata <= '0;
                end
            end

            if (grant_fetch) begin
                lat_addr  <= if_addr;
                lat_we    <= 1'b0;
                lat_size  <= SZ_WORD;
                lat_wdata <= '0;
            end

            if (complete) begin
                if (acc_data) begin
                    // Memory places the addressed byte in the low lane.
                    if (lat_size == SZ_BYTE) begin
                        dm_rdata <= {{(DATA_W-8){1'b0}}, mem_rdata[7:0]};
                    end else begin
                        dm_rdata <= mem_rdata;
                    end
                end else begin
                    if_rdata <= mem_rdata;
                end
            end

`ifdef MEM_TIMEOUT_EN
            if (abort) begin
                if (acc_data) begin
                    dm_rdata <= '0;
                end else begin
                    if_rdata <= NOP_WORD;
                end
            end
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Outputs decoded from registered state
    // -----------------------------------------------------------------------
    always_comb begin
        mem_en    = (state == FETCH) || (state == DATA);
        mem_we    = lat_we && mem_en;
        mem_size  = lat_size;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;

        if_done   = (state == DONE) && !acc_data;
        pc_write  = if_done;
        dm_done   = (state == DONE) && acc_data;
        dm_err    = dm_done && acc_err;
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mem_access_sequencer
// Scoreboard bench: requester tasks push expected completions (and the
// expected memory grant order) into queues; monitors pop and compare when
// the sequencer reports done or starts a memory access. A behavioural
// memory with programmable latency answers the memory port.
// ---------------------------------------------------------------------------
module tb_mem_access_sequencer;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              Clk;
    logic              Reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;
    logic              pc_write;
    logic              dm_req;
    logic              dm_we;
    logic [1:0]        dm_size;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_done;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_err;
    logic              mem_en;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    mem_access_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DATA_BURST(4), .TIMEOUT(16)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
        .if_rdata(if_rdata), .pc_write(pc_write),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Scoreboard queues
    logic [31:0] exp_if[$];
    logic [33:0] exp_dm[$];     // {check_rdata, err, rdata}
    logic [32:0] exp_grant[$];  // {we, addr}

    // Behavioural memory
    logic [31:0] mem_words [0:127];
    int          lat     = 2;   // 0 = never ready
    int          en_cnt  = 0;
    int          last_en = 0;
    int          grants  = 0;

    function automatic logic [31:0] init_val(input int idx);
        if (idx == 0) return 32'h2401_002C;
        return 32'hA500_0000 + 32'(idx) * 32'h0101;
    endfunction

    initial begin
        logic [6:0]  idx;
        logic [31:0] w;
        logic [31:0] sh;
        logic [32:0] g;
        for (int i = 0; i < 128; i++) mem_words[i] = init_val(i);
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge Clk);
            if (mem_en && Reset) begin
                en_cnt++;
                last_en = en_cnt;
                if (en_cnt == 1) begin
                    grants++;
                    if (exp_grant.size() > 0) begin
                        g = exp_grant.pop_front();
                        check("grant_order", {mem_we, mem_addr}, g);
                    end
                end
                if (lat != 0 && en_cnt == lat) begin
                    idx = mem_addr[8:2];
                    if (mem_we) begin
                        if (mem_size == 2'b10) mem_words[idx] = mem_wdata;
                        else mem_words[idx][8*int'(mem_addr[1:0]) +: 8] = mem_wdata[7:0];
                    end
                    w  = mem_words[idx];
                    sh = w >> (8 * int'(mem_addr[1:0]));
                    mem_rdata = (mem_size == 2'b10) ? w : {24'hFF_FFFF, sh[7:0]};
                    mem_ready = 1'b1;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                end
            end else begin
                mem_ready = 1'b0;
                en_cnt    = 0;
            end
        end
    end

    // Completion monitor
    logic prev_if = 1'b0;
    logic prev_dm = 1'b0;
    initial begin
        logic [31:0] ei;
        logic [33:0] ed;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                if (if_done || pc_write) check("pc_write", pc_write, if_done);
                if (prev_if) check("if_done_pulse", if_done, 0);
                if (prev_dm) check("dm_done_pulse", dm_done, 0);
                if (if_done) begin
                    if (exp_if.size() == 0) check("if_unexpected", if_done, 0);
                    else begin
                        ei = exp_if.pop_front();
                        check("if_rdata", if_rdata, ei);
                    end
                end
                if (dm_done) begin
                    if (exp_dm.size() == 0) check("dm_unexpected", dm_done, 0);
                    else begin
                        ed = exp_dm.pop_front();
                        if (ed[33]) check("dm_rdata", dm_rdata, ed[31:0]);
                        check("dm_err", dm_err, ed[32]);
                    end
                end
                prev_if = if_done;
                prev_dm = dm_done;
            end else begin
                prev_if = 1'b0;
                prev_dm = 1'b0;
            end
        end
    end

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_word);
        logic seen = 1'b0;
        if_addr = addr;
        if_req  = 1'b1;
        exp_if.push_back(exp_word);
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge Clk);
            if (if_done) seen = 1'b1;
        end
        check("if_done_seen", seen, 1);
        if_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd, input logic chk, input logic [31:0] rd,
                           input logic err);
        logic seen = 1'b0;
        dm_we    = we;
        dm_size  = sz;
        dm_addr  = addr;
        dm_wdata = wd;
        dm_req   = 1'b1;
        exp_dm.push_back({chk, err, rd});
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge Clk);
            if (dm_done) seen = 1'b1;
        end
        check("dm_done_seen", seen, 1);
        dm_req = 1'b0;
    endtask

    initial begin
        int  g0;
        logic seen;
        Reset = 1'b0; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_size = 2'b00; dm_addr = '0; dm_wdata = '0;
        repeat (3) @(negedge Clk);
        check("rst_mem_en",   mem_en,   0);
        check("rst_mem_we",   mem_we,   0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_size", mem_size, 0);
        check("rst_if_done",  if_done,  0);
        check("rst_pc_write", pc_write, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_dm_done",  dm_done,  0);
        check("rst_dm_err",   dm_err,   0);
        check("rst_dm_rdata", dm_rdata, 0);
        Reset = 1'b1;
        @(negedge Clk);

        // Single fetch, memory ready after 2 cycles
        lat = 2;
        exp_grant.push_back({1'b0, 32'h00});
        do_fetch(32'h00, 32'h2401_002C);
        check("fetch_en_cycles", last_en, 2);
        check("fetch_mem_size", mem_size, 2'b10);
        @(negedge Clk);

        // Simultaneous store and fetch: data first
        exp_grant.push_back({1'b1, 32'h20});
        exp_grant.push_back({1'b0, 32'h04});
        fork
            do_data(1'b1, 2'b10, 32'h20, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
            do_fetch(32'h04, init_val(1));
        join
        check("store_word_mem", mem_words[8], 32'hDEAD_BEEF);
        @(negedge Clk);

        // Burst limit: D D D D F D D
        for (int i = 0; i < 4; i++) exp_grant.push_back({1'b0, 32'h40 + 32'(4 * i)});
        exp_grant.push_back({1'b0, 32'h100});
        exp_grant.push_back({1'b0, 32'h50});
        exp_grant.push_back({1'b0, 32'h54});
        fork
            do_fetch(32'h100, init_val(64));
            begin
                for (int i = 0; i < 6; i++)
                    do_data(1'b0, 2'b10, 32'h40 + 32'(4 * i), 32'h0, 1'b1, init_val(16 + i), 1'b0);
            end
        join
        check("burst_grants_left", exp_grant.size(), 0);
        @(negedge Clk);

        // Byte store then byte load with zero extension
        lat = 3;
        do_data(1'b1, 2'b00, 32'h21, 32'hFFFF_FF85, 1'b0, 32'h0, 1'b0);
        check("store_byte_mem", mem_words[8], 32'hDEAD_85EF);
        do_data(1'b0, 2'b00, 32'h21, 32'h0, 1'b1, 32'h0000_0085, 1'b0);
        do_data(1'b0, 2'b10, 32'h24, 32'h0, 1'b1, init_val(9), 1'b0);

        // Illegal accesses: never reach memory
        g0 = grants;
        do_data(1'b0, 2'b10, 32'h22, 32'h0, 1'b1, 32'h0, 1'b1);
        do_data(1'b1, 2'b01, 32'h24, 32'h1234, 1'b1, 32'h0, 1'b1);
        do_data(1'b0, 2'b11, 32'h28, 32'h0, 1'b1, 32'h0, 1'b1);
        check("illegal_no_mem", grants, g0);
        @(negedge Clk);

        // Reset in the middle of a data access
        lat = 6;
        dm_we = 1'b0; dm_size = 2'b10; dm_addr = 32'h28; dm_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge Clk);
            if (mem_en) seen = 1'b1;
        end
        check("rst_test_en_seen", seen, 1);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("rst_mid_mem_en",  mem_en,  0);
        check("rst_mid_dm_done", dm_done, 0);
        check("rst_mid_if_done", if_done, 0);
        dm_req = 1'b0;
        lat = 2;
        exp_grant.push_back({1'b0, 32'h0C});
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("rst_release_en", mem_en, 0);
        do_fetch(32'h0C, init_val(3));
        @(negedge Clk);

`ifdef MEM_TIMEOUT_EN
        // Memory never answers: access abandoned after 16 mem_en cycles
        lat = 0;
        do_data(1'b0, 2'b10, 32'h30, 32'h0, 1'b1, 32'h0, 1'b1);
        check("tmo_data_en_cycles", last_en, 16);
        do_fetch(32'h34, 32'h0000_0000);
        check("tmo_fetch_en_cycles", last_en, 16);
        lat = 2;
        @(negedge Clk);
`endif

        repeat (5) @(negedge Clk);
        check("sb_if_empty", exp_if.size(), 0);
        check("sb_dm_empty", exp_dm.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Sequences a single unified memory port shared by instruction fetch and data load/store.
- Serialises both requesters; data has priority with a bounded-starvation rule.
- Drives PCWrite so the PC advances only when a fetch completes.
- Sits between the ProgramCounter/control unit and a variable-latency memory with a ready handshake.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (fixed at 32 for byte-lane logic).
- MAX_DATA_BURST, 4, max consecutive data grants while a fetch is pending.
- TIMEOUT, 16, cycles to wait for mem_ready (used only with the optional feature).

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset (0 = reset)
- if_req  in  1  fetch request, level held until if_done
- if_addr  in  ADDR_W  fetch address (PC)
- if_done  out  1  one-cycle pulse: fetch complete
- if_rdata  out  32  fetched instruction, valid with if_done, held until next if_done
- pc_write  out  1  equals if_done; drives ProgramCounter PCWrite
- dm_req  in  1  data request, level held until dm_done
- dm_we  in  1  1 = store, 0 = load
- dm_size  in  2  00 byte, 10 word, others illegal
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  32  store data (byte in [7:0])
- dm_done  out  1  one-cycle pulse: data access complete
- dm_rdata  out  32  load data (byte zero-extended), valid with dm_done
- dm_err  out  1  with dm_done: access was illegal/aborted
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_size  out  2  forwarded size (10 for fetch)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid with mem_ready
- mem_ready  in  1  access complete this cycle

Behaviour:
- Reset low: state IDLE. All outputs 0, burst counter 0. Takes effect immediately, including mid-access. After release, the first access starts no earlier than the next edge.
- FSM states: IDLE, FETCH, DATA, DONE.
- IDLE, selection sampled at the edge:
  - dm_req and (burst_cnt < MAX_DATA_BURST or !if_req) -> DATA.
  - Otherwise if_req -> FETCH.
  - Otherwise stay in IDLE.
- Request latching: address, we, size and wdata are latched on the IDLE->FETCH/DATA edge. mem_* outputs are registered from the latches and stay stable while mem_en = 1.
- FETCH/DATA:
  - mem_en = 1 until mem_ready is sampled high.
  - On that edge: capture mem_rdata and go to DONE.
  - Minimum one mem_en cycle.
- DONE:
  - Exactly one cycle.
  - The matching done pulses, so pc_write = if_done.
  - mem_en = 0. Returns to IDLE.
- Latency: request sampled in IDLE at edge t -> mem_en high t+1 -> mem_ready at edge t+k (k >= 1) -> done high during cycle t+k+1.
- Back-to-back spacing: minimum 3 cycles between starts (DONE and IDLE both present).
- Burst counter:
  - Increments on each data grant taken while if_req = 1.
  - Clears on any fetch grant.
  - Saturates at MAX_DATA_BURST.
- Illegal data access: dm_size not in {00, 10}, or word with dm_addr[1:0] != 0.
  - No memory access (mem_en stays 0).
  - IDLE -> DONE directly, with dm_done = 1, dm_err = 1, dm_rdata = 0.
- Fetch is never checked for alignment.
- Byte load: dm_rdata = {24'b0, mem_rdata[7:0]}. The memory returns the addressed byte in the low lane.
- Requester drops req mid-access: the access still completes, and the done pulse is still issued.
- Simultaneous if_req and dm_req with burst_cnt = MAX_DATA_BURST: fetch is granted.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter runs in FETCH/DATA.
  - If mem_ready has not arrived after TIMEOUT mem_en cycles: drop mem_en, go to DONE, pulse done.
  - Data side: dm_err = 1. Fetch side: if_rdata = 32'h0000_0000 (NOP).
- Undefined: waits forever; no counter logic is present.

Decomposition:
- Shared package mem_seq_pkg holds:
  - state encoding: IDLE = 2'd0, FETCH = 2'd1, DATA = 2'd2, DONE = 2'd3;
  - size constants: SZ_BYTE = 2'b00, SZ_WORD = 2'b10;
  - the NOP word.
- One natural sub-module: mem_seq_legal_chk, a combinational size/alignment check.

Test Plan:
- Fetch at 0x00, memory ready after 2 cycles, mem_rdata = 0x2401002C -> if_done/pc_write pulse one cycle, if_rdata = 0x2401002C, mem_en high exactly 2 cycles.
- if_req and dm_req both held, store word 0x20 = 0xDEADBEEF -> data access first (mem_we = 1, mem_addr = 0x20), then fetch.
- if_req held, dm_req held for 6 loads, MAX_DATA_BURST = 4 -> grant order D, D, D, D, F, D, D.
- Load byte at 0x21, mem_rdata = 0xFFFFFF85 -> dm_rdata = 0x00000085; word load at 0x22 -> dm_done with dm_err = 1, mem_en never asserted.
- Reset pulled low while mem_en = 1 in DATA -> mem_en = 0 immediately, no done pulse; after release, pending if_req is served normally.
- With MEM_TIMEOUT_EN and TIMEOUT = 16, mem_ready never asserted on a load -> dm_done with dm_err = 1 in the cycle after the 16th mem_en cycle.
